// File: rtl/jtdd_main_romfetch.sv
// Main-CPU program ROM fetcher for the Double Dragon core.
// Two-entry 32-bit word cache in front of the SDRAM port, with optional
// sequential prefetch of the word after the one currently being hit.
// rom_ok/rom_data are combinational on the registered storage so hits
// cost zero cycles; misses stall the CPU through rom_ok.
module jtdd_main_romfetch #(
    parameter bit PREFETCH = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        rom_cs,
    input  logic [17:0] rom_addr,
    output logic [7:0]  rom_data,
    output logic        rom_ok,
    output logic [15:0] sdram_addr,
    output logic        sdram_req,
    input  logic        sdram_ack,
    input  logic        sdram_dst,
    input  logic [31:0] sdram_data
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    // Little-endian byte lane select: lane 0 is word[7:0].
    function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Registered state
    state_t      state_r;
    logic [1:0]  valid_r;
    logic [15:0] tag0_r;
    logic [15:0] tag1_r;
    logic [31:0] data0_r;
    logic [31:0] data1_r;
    logic        lru_r;       // entry to evict on the next demand miss
    logic        victim_r;    // entry the in-flight fill will land in
    logic        discard_r;   // a flush hit the in-flight request
    logic [15:0] sdram_addr_r;
    logic        sdram_req_r;

    // Combinational decode
    logic [15:0] cpu_tag_s;
    logic        hit0_s;
    logic        hit1_s;
    logic        hit_s;
    logic        hit_idx_s;
    logic [15:0] hit_tag_s;
    logic [31:0] hit_word_s;
    logic [15:0] next_tag_s;
    logic        next_held_s;
    logic        idle_s;
    logic        demand_s;
    logic        pf_s;
    logic        fill_s;

    // Hit detection against both entries and selection of the hitting entry.
    always_comb begin
        cpu_tag_s = rom_addr[17:2];
        hit0_s    = rom_cs & valid_r[0] & (tag0_r == cpu_tag_s);
        hit1_s    = rom_cs & valid_r[1] & (tag1_r == cpu_tag_s);
        hit_s     = hit0_s | hit1_s;
        // Entry 0 wins if both ever match; with no hit entry 0 drives the bus.
        hit_idx_s = ~hit0_s & hit1_s;
        if (hit_idx_s) begin
            hit_tag_s  = tag1_r;
            hit_word_s = data1_r;
        end else begin
            hit_tag_s  = tag0_r;
            hit_word_s = data0_r;
        end
    end

    // Prefetch candidate: word after the hit tag, 16-bit wrap, unless already cached.
    always_comb begin
        next_tag_s  = hit_tag_s + 16'd1;
        next_held_s = (valid_r[0] & (tag0_r == next_tag_s)) |
                      (valid_r[1] & (tag1_r == next_tag_s));
    end

    // Request launch and fill qualifiers. A flush in IDLE suppresses launch
    // because the hit decode that cycle still sees the pre-flush valid bits.
    always_comb begin
        idle_s   = (state_r == ST_IDLE);
        demand_s = idle_s & ~flush & rom_cs & ~hit_s;
        if (PREFETCH) begin
            pf_s = idle_s & ~flush & ~demand_s & hit_s & ~next_held_s;
        end else begin
            pf_s = 1'b0;
        end
        fill_s   = (state_r == ST_WAIT) & sdram_dst;
    end

    // CPU-side outputs: zero-latency hit path.
    always_comb begin
        rom_ok   = hit_s;
        rom_data = byte_sel(hit_word_s, rom_addr[1:0]);
    end

    assign sdram_addr = sdram_addr_r;
    assign sdram_req  = sdram_req_r;

    // Fetch FSM: launch demand/prefetch requests and run the SDRAM handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            sdram_req_r  <= 1'b0;
            sdram_addr_r <= 16'h0000;
            victim_r     <= 1'b0;
            discard_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    discard_r <= 1'b0;
                    if (demand_s) begin
                        sdram_addr_r <= cpu_tag_s;
                        victim_r     <= lru_r;
                        sdram_req_r  <= 1'b1;
                        state_r      <= ST_REQ;
                    end else if (pf_s) begin
                        // Prefetch goes into the entry not being read right now.
                        sdram_addr_r <= next_tag_s;
                        victim_r     <= ~hit_idx_s;
                        sdram_req_r  <= 1'b1;
                        state_r      <= ST_REQ;
                    end else begin
                        sdram_req_r  <= 1'b0;
                        state_r      <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (flush) begin
                        discard_r <= 1'b1;
                    end else begin
                        discard_r <= discard_r;
                    end
                    if (sdram_ack) begin
                        sdram_req_r <= 1'b0;
                        state_r     <= ST_WAIT;
                    end else begin
                        sdram_req_r <= 1'b1;
                        state_r     <= ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (fill_s) begin
                        discard_r <= 1'b0;
                        state_r   <= ST_IDLE;
                    end else if (flush) begin
                        discard_r <= 1'b1;
                        state_r   <= ST_WAIT;
                    end else begin
                        state_r   <= ST_WAIT;
                    end
                end
                default: begin
                    sdram_req_r <= 1'b0;
                    discard_r   <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    // Entry storage: write tag/data on fill, validate unless a flush intervened.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= 2'b00;
            tag0_r  <= 16'h0000;
            tag1_r  <= 16'h0000;
            data0_r <= 32'h0000_0000;
            data1_r <= 32'h0000_0000;
        end else begin
            if (fill_s) begin
                if (victim_r) begin
                    tag1_r  <= sdram_addr_r;
                    data1_r <= sdram_data;
                end else begin
                    tag0_r  <= sdram_addr_r;
                    data0_r <= sdram_data;
                end
            end
            if (flush) begin
                valid_r <= 2'b00;
            end else if (fill_s && !discard_r) begin
                valid_r[victim_r] <= 1'b1;
            end else begin
                valid_r <= valid_r;
            end
        end
    end

    // Replacement pointer: a fill or a hit makes the other entry the victim.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lru_r <= 1'b0;
        end else if (fill_s) begin
            lru_r <= ~victim_r;
        end else if (hit_s) begin
            lru_r <= ~hit_idx_s;
        end else begin
            lru_r <= lru_r;
        end
    end

endmodule
